// File: rtl/ls_access_ctrl_if.sv
// ---------------------------------------------------------------------------
// ls_access_ctrl_if
//   Request/response bundle between one local-store requester (odd pipe or
//   DMA/MFC) and ls_access_ctrl.
//
//   req_valid/req_ready : quadword access handshake (accepted on valid&ready)
//   req_we              : 1=store, 0=load
//   req_addr            : 18-bit byte address, low 4 bits ignored
//   req_wdata           : 128-bit store data
//   req_tag             : load tag, echoed back on rsp_tag
//   rsp_valid/rsp_ready : load data handshake
//   rsp_data/rsp_tag    : returned load data and its tag
//
//   master : requester side.  slave : controller side.
// ---------------------------------------------------------------------------
interface ls_access_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [17:0]      req_addr;
    logic [127:0]     req_wdata;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [127:0]     rsp_data;
    logic [TAG_W-1:0] rsp_tag;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_tag
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_tag
    );
endinterface

// File: rtl/ls_access_ctrl.sv
// ---------------------------------------------------------------------------
// ls_access_ctrl
//   Access controller in front of the 256KB local store RAM. Arbitrates
//   quadword loads/stores from the odd pipe and the DMA engine (fixed DMA
//   priority with a starvation guard for the pipe), drives the LS pins
//   combinationally in the accept cycle, and captures the registered LS read
//   data into a one-entry response buffer per requester.
//
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     pipe       : ls_access_ctrl_if.slave, odd-pipe requester
//     dma        : ls_access_ctrl_if.slave, DMA/MFC requester
//     ls_ce      : LS chip enable (1 only in an accept cycle)
//     ls_we      : LS write enable
//     ls_addr    : LS address, quadword aligned
//     ls_wdata   : LS write data
//     ls_rdata   : LS read data, valid the cycle after a read is issued
//
//   Optional build macro LS_ACCESS_STATS_EN adds wrap-around counters:
//     stat_rd_cnt       : accepted loads
//     stat_wr_cnt       : accepted stores
//     stat_conflict_cnt : cycles with both requesters valid and eligible
//
//   Load latency: accept in N, ls_rdata in N+1, rsp_valid in N+2.
// ---------------------------------------------------------------------------

// Per-requester load tracking: one in-flight flag, the tag of that load, and
// the response buffer that holds data until the requester takes it.
module ls_access_port #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_ld,   // this requester's load won this cycle
    input  logic [TAG_W-1:0] req_tag,
    input  logic             rsp_ready,
    input  logic [127:0]     ls_rdata,
    output logic             ld_ok,      // a load from this requester may be accepted
    output logic             rsp_valid,
    output logic [127:0]     rsp_data,
    output logic [TAG_W-1:0] rsp_tag
);
    logic             inflight;
    logic [TAG_W-1:0] tag_q;

    // The buffer counts as free when it is being drained this cycle, which
    // lets a requester sustain one load every two cycles.
    assign ld_ok = !inflight && (!rsp_valid || rsp_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight  <= 1'b0;
            tag_q     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
        end else begin
            inflight <= issue_ld;
            if (issue_ld)
                tag_q <= req_tag;
            // A capture beats a drain on the same edge: new data stays valid.
            if (inflight) begin
                rsp_valid <= 1'b1;
                rsp_data  <= ls_rdata;
                rsp_tag   <= tag_q;
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

module ls_access_ctrl #(
    parameter int TAG_W      = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    ls_access_ctrl_if.slave      pipe,
    ls_access_ctrl_if.slave      dma,
    output logic                 ls_ce,
    output logic                 ls_we,
    output logic [17:0]          ls_addr,
    output logic [127:0]         ls_wdata,
    input  logic [127:0]         ls_rdata
`ifdef LS_ACCESS_STATS_EN
    ,
    output logic [31:0]          stat_rd_cnt,
    output logic [31:0]          stat_wr_cnt,
    output logic [31:0]          stat_conflict_cnt
`endif
);
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [17:0]   QW_MASK    = 18'h3fff0;

    logic          p_ld_ok, d_ld_ok;
    logic          p_el, d_el, both_el;
    logic          p_win, d_win;
    logic [SW-1:0] starve_cnt;

    // ------------------------------------------------------------------
    // Eligibility and arbitration. Everything is gated by rst so that no
    // request is accepted and the LS stays idle while reset is held.
    // ------------------------------------------------------------------
    always_comb begin
        p_el    = !rst && pipe.req_valid && (pipe.req_we || p_ld_ok);
        d_el    = !rst && dma.req_valid  && (dma.req_we  || d_ld_ok);
        both_el = p_el && d_el;
        // DMA has priority unless the pipe has lost STARVE_MAX times in a row.
        p_win   = p_el && (!d_el || (starve_cnt == STARVE_LIM));
        d_win   = d_el && !p_win;
    end

    assign pipe.req_ready = p_win;
    assign dma.req_ready  = d_win;

    // ------------------------------------------------------------------
    // LS pins: driven straight from the winner; all zero when idle.
    // ------------------------------------------------------------------
    always_comb begin
        ls_ce    = 1'b0;
        ls_we    = 1'b0;
        ls_addr  = '0;
        ls_wdata = '0;
        if (p_win) begin
            ls_ce    = 1'b1;
            ls_we    = pipe.req_we;
            ls_addr  = pipe.req_addr & QW_MASK;
            ls_wdata = pipe.req_wdata;
        end else if (d_win) begin
            ls_ce    = 1'b1;
            ls_we    = dma.req_we;
            ls_addr  = dma.req_addr & QW_MASK;
            ls_wdata = dma.req_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts consecutive eligible losses of the pipe.
    // Holds while the pipe is valid but ineligible (waiting on its own load).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)
            starve_cnt <= '0;
        else if (!pipe.req_valid || p_win)
            starve_cnt <= '0;
        else if (p_el && (starve_cnt != STARVE_LIM))
            starve_cnt <= starve_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // Response buffers. Only one read is issued per cycle, so at most one
    // in-flight flag is set on any capture edge and ls_rdata has one owner.
    // ------------------------------------------------------------------
    ls_access_port #(.TAG_W(TAG_W)) u_pipe_port (
        .clk       (clk),
        .rst       (rst),
        .issue_ld  (p_win && !pipe.req_we),
        .req_tag   (pipe.req_tag),
        .rsp_ready (pipe.rsp_ready),
        .ls_rdata  (ls_rdata),
        .ld_ok     (p_ld_ok),
        .rsp_valid (pipe.rsp_valid),
        .rsp_data  (pipe.rsp_data),
        .rsp_tag   (pipe.rsp_tag)
    );

    ls_access_port #(.TAG_W(TAG_W)) u_dma_port (
        .clk       (clk),
        .rst       (rst),
        .issue_ld  (d_win && !dma.req_we),
        .req_tag   (dma.req_tag),
        .rsp_ready (dma.rsp_ready),
        .ls_rdata  (ls_rdata),
        .ld_ok     (d_ld_ok),
        .rsp_valid (dma.rsp_valid),
        .rsp_data  (dma.rsp_data),
        .rsp_tag   (dma.rsp_tag)
    );

`ifdef LS_ACCESS_STATS_EN
    // ------------------------------------------------------------------
    // Access statistics, wrap-around.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_cnt       <= '0;
            stat_wr_cnt       <= '0;
            stat_conflict_cnt <= '0;
        end else begin
            if (ls_ce && !ls_we)
                stat_rd_cnt <= stat_rd_cnt + 32'd1;
            if (ls_ce && ls_we)
                stat_wr_cnt <= stat_wr_cnt + 32'd1;
            if (both_el)
                stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
        end
    end
`else
    // both_el only feeds the statistics block.
    logic unused_both_el;
    assign unused_both_el = both_el;
`endif

endmodule

// File: doc/ls_access_ctrl.md
Name: ls_access_ctrl

Overview:
- Access controller directly upstream of the 256KB local store (LS) RAM.
- Arbitrates quadword load/store requests from two requesters: the odd-pipe load/store unit (pipe) and the DMA/MFC engine (dma).
- Drives the LS ce/we/addr/data_i pins and captures the LS registered read data into per-requester response buffers with valid/ready backpressure.

Parameters:
- TAG_W, 4, width of the request/response tag carried with each load.
- STARVE_MAX, 4, consecutive cycles pipe may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock; all logic is posedge.
- rst  in  1  synchronous, active-high reset.
- pipe_req_valid  in  1  pipe request present.
- pipe_req_ready  out  1  pipe request accepted this cycle (valid&ready).
- pipe_req_we  in  1  1=store, 0=load.
- pipe_req_addr  in  18  byte address; low 4 bits ignored.
- pipe_req_wdata  in  128  store data.
- pipe_req_tag  in  TAG_W  load tag.
- pipe_rsp_valid  out  1  load data available.
- pipe_rsp_ready  in  1  pipe consumes response.
- pipe_rsp_data  out  128  load data.
- pipe_rsp_tag  out  TAG_W  tag of returned load.
- dma_req_valid, dma_req_ready, dma_req_we, dma_req_addr, dma_req_wdata, dma_req_tag: same as the pipe_req_* ports, for the DMA requester.
- dma_rsp_valid, dma_rsp_ready, dma_rsp_data, dma_rsp_tag: same as the pipe_rsp_* ports, for the DMA requester.
- ls_ce  out  1  LS chip enable (1=enabled).
- ls_we  out  1  LS write enable (1=write).
- ls_addr  out  18  LS address, always quadword aligned.
- ls_wdata  out  128  to LS data_i.
- ls_rdata  in  128  from LS data_o; valid the cycle after a read is issued.

Behaviour:
- Reset is synchronous and active-high. While rst=1 at posedge:
  - ls_ce=0, ls_we=0, ls_addr=0, ls_wdata=0.
  - both rsp_valid=0, rsp_data=0, rsp_tag=0.
  - both req_ready=0; starvation counter=0; in-flight read discarded.
- LS outputs are combinational from the arbitration winner in the accept cycle (one access per cycle):
  - ls_addr = req_addr & 18'h3fff0.
  - ls_we = winner we; ls_wdata = winner wdata.
  - ls_ce=1 only in a cycle with an accepted request; otherwise ls_ce=0, ls_we=0, ls_addr=0, ls_wdata=0.
- Eligibility:
  - A store is always eligible.
  - A load is eligible only if that requester has no load in flight and its response buffer is empty, or is being drained this cycle (rsp_valid&rsp_ready).
- Arbitration (fixed DMA priority with starvation guard):
  - If both are valid and eligible, dma wins, unless starve_cnt==STARVE_MAX, in which case pipe wins.
  - starve_cnt increments, saturating at STARVE_MAX, each cycle pipe is valid+eligible but loses. It clears when pipe wins or pipe_req_valid=0.
  - Only the winner sees req_ready=1. A requester that is valid but ineligible does not block the other.
- Load timing:
  - Cycle N: accept; LS read issued.
  - Cycle N+1: ls_rdata valid; captured at the end of N+1 into the owner's rsp_data/rsp_tag.
  - Cycle N+2: rsp_valid=1. Load latency from acceptance to rsp_valid = 2 cycles.
  - Each requester keeps one in-flight owner flag plus its registered tag.
- Response hold:
  - rsp_valid, rsp_data and rsp_tag hold stable until rsp_ready=1.
  - rsp_valid falls the cycle after the handshake unless a new capture lands on that same edge; back-to-back loads therefore sustain 1 load per 2 cycles per requester.
- Stores:
  - Complete in the accept cycle (LS writes at that posedge); no response generated.
  - A load to the same quadword accepted the next cycle returns the new data.
- Simultaneous events:
  - A capture and a drain on the same edge means the new data wins; rsp_valid stays 1.
  - The two requesters' loads may be in flight in different cycles, never the same cycle.
- Reset mid-operation: in-flight loads are dropped; no response is produced after reset deasserts.

Optional Feature:
- Macro LS_ACCESS_STATS_EN. When defined, adds outputs:
  - stat_rd_cnt (32): accepted loads.
  - stat_wr_cnt (32): accepted stores.
  - stat_conflict_cnt (32): cycles where both requesters were valid+eligible.
- All three are wrap-around counters, cleared by rst.
- When not defined, these ports and counters do not exist; functional behaviour is identical.

Test Plan:
- Store then load:
  - pipe store addr=18'h00123, wdata=128'hA5..A5, next cycle pipe load addr=18'h00120, tag=3.
  - Expect: ls_addr=18'h00120 both cycles; pipe_rsp_valid two cycles after the load accept; data=128'hA5..A5, tag=3.
- Conflict: pipe and dma both issue continuous loads with rsp_ready=1.
  - Expect: dma wins; pipe is accepted no later than after STARVE_MAX=4 consecutive losses; no starvation.
- Backpressure:
  - dma load tag=7, dma_rsp_ready=0 for 10 cycles.
  - Expect: dma_rsp_valid stays 1 with stable data/tag; dma_req_ready=0 for a second dma load; pipe loads still accepted.
- Idle outputs: no valid requests for 5 cycles.
  - Expect: ls_ce=0, ls_we=0, ls_addr=0 every cycle.
- Reset mid-load:
  - rst=1 in the cycle after a pipe load accept.
  - Expect: pipe_rsp_valid=0 during and after reset; no stray response.
- Stats (LS_ACCESS_STATS_EN defined):
  - 3 stores, 2 loads, 1 conflict cycle.
  - Expect: stat_wr_cnt=3, stat_rd_cnt=2, stat_conflict_cnt=1.
